// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU.
//   op_e    : 3-bit opcode encoding
//   state_e : control FSM states
//   Flag*   : bit positions inside the 4-bit flags output {dz, ov, cy, z}
package iter_alu_pkg;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b010,
        OpSub = 3'b011,
        OpMul = 3'b100,
        OpDiv = 3'b101,
        OpRem = 3'b110,
        OpXor = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned FlagZ  = 0;
    localparam int unsigned FlagCy = 1;
    localparam int unsigned FlagOv = 2;
    localparam int unsigned FlagDz = 3;

endpackage

// File: rtl/iter_alu_muldiv.sv
// Iterative multiply / divide engine, one bit per cycle.
// Optional divider: define ITER_ALU_DIV_EN to build the restoring divider.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           load operands (a -> low half, b -> operand reg), clear counter
//   i_div             (ITER_ALU_DIV_EN only) select divide instead of multiply
//   i_step            perform one iteration this cycle
//   i_a, i_b          operands
//   o_last            current step is the final (WIDTH-th) iteration
//   o_hi_next/lo_next register contents after the current step
//                     multiply: {hi,lo} = product; divide: hi = remainder, lo = quotient
module iter_alu_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef ITER_ALU_DIV_EN
    input  logic             i_div,
`endif
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    // hi: accumulator / partial remainder, lo: multiplier / quotient, opnd: multiplicand / divisor
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CntW-1:0]  r_cnt;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift the
    // {carry, hi, lo} chain right by one.
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_hi} + ({(WIDTH + 1){r_lo[0]}} & {1'b0, r_opnd});

`ifdef ITER_ALU_DIV_EN
    logic           r_div;
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;

    // Restoring step: shift the next dividend bit into the remainder, trial-subtract.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
`endif

    always_comb begin
        o_hi_next = w_mul_sum[WIDTH:1];
        o_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef ITER_ALU_DIV_EN
        if (r_div) begin
            // A clear top bit means the trial subtraction did not go negative.
            if (!w_div_diff[WIDTH]) begin
                o_hi_next = w_div_diff[WIDTH-1:0];
                o_lo_next = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi_next = w_div_shift[WIDTH-1:0];
                o_lo_next = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign o_last = i_step && (r_cnt == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
`ifdef ITER_ALU_DIV_EN
            r_div  <= 1'b0;
`endif
        end else if (i_start) begin
            r_hi   <= '0;
            r_lo   <= i_a;
            r_opnd <= i_b;
            r_cnt  <= '0;
`ifdef ITER_ALU_DIV_EN
            r_div  <= i_div;
`endif
        end else if (i_step) begin
            r_hi  <= o_hi_next;
            r_lo  <= o_lo_next;
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: valid/ready handshake, control FSM, single-cycle logic/arith ops
// and flag generation. MUL (and DIV/REM when enabled) run in iter_alu_muldiv.
// Optional divider: define ITER_ALU_DIV_EN; when undefined DIV/REM finish in one
// cycle with result 0 and dz = 1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (ready only when idle)
//   op, a, b            opcode and unsigned operands
//   out_valid/out_ready result handshake; result/flags held until taken
//   result              2*WIDTH bits (full product for MUL, zero-extended otherwise)
//   flags               {dz, ov, cy, z}
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags
);

    state_e             r_state;
    state_e             w_state_next;
    logic [2*WIDTH-1:0] r_result;
    logic [3:0]         r_flags;

    op_e                w_op;
    logic               w_accept;
    logic               w_long;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_q_res;
    logic [3:0]         w_q_flags;
    logic [2*WIDTH-1:0] w_l_res;
    logic [3:0]         w_l_flags;
    logic               w_md_last;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;

    assign w_op     = op_e'(op);
    assign w_accept = in_valid && in_ready;

    // Operations that need the iterative engine; division by zero short-circuits.
`ifdef ITER_ALU_DIV_EN
    op_e r_op;
    assign w_long = (w_op == OpMul) || (((w_op == OpDiv) || (w_op == OpRem)) && (b != '0));
`else
    assign w_long = (w_op == OpMul);
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = w_long ? StBusy : StDone;
            StBusy:  if (w_md_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    // ---------------- Single-cycle datapath ----------------
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};   // top bit is the borrow (a < b)

    always_comb begin
        w_q_res   = '0;
        w_q_flags = '0;
        case (w_op)
            OpAnd: w_q_res = a & b;
            OpOr:  w_q_res = a | b;
            OpXor: w_q_res = a ^ b;
            OpAdd: begin
                w_q_res           = w_add[WIDTH-1:0];
                w_q_flags[FlagCy] = w_add[WIDTH];
                w_q_flags[FlagOv] = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                w_q_res           = w_sub[WIDTH-1:0];
                w_q_flags[FlagCy] = w_sub[WIDTH];
                w_q_flags[FlagOv] = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OpMul: w_q_res = '0;
            // Only reached on the short path: divisor zero, or divider not built.
            OpDiv: begin
`ifdef ITER_ALU_DIV_EN
                w_q_res = '1;
`endif
                w_q_flags[FlagDz] = 1'b1;
            end
            OpRem: begin
`ifdef ITER_ALU_DIV_EN
                w_q_res = a;
`endif
                w_q_flags[FlagDz] = 1'b1;
            end
        endcase
        w_q_flags[FlagZ] = (w_q_res == '0);
    end

    // ---------------- Iterative result selection ----------------
    always_comb begin
        w_l_res = {w_md_hi, w_md_lo};
`ifdef ITER_ALU_DIV_EN
        if (r_op == OpDiv) begin
            w_l_res = {{WIDTH{1'b0}}, w_md_lo};
        end else if (r_op == OpRem) begin
            w_l_res = {{WIDTH{1'b0}}, w_md_hi};
        end
`endif
        w_l_flags        = '0;
        w_l_flags[FlagZ] = (w_l_res == '0);
    end

    // ---------------- Result / flag registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept && !w_long) begin
            r_result <= {{WIDTH{1'b0}}, w_q_res};
            r_flags  <= w_q_flags;
        end else if (w_md_last) begin
            r_result <= w_l_res;
            r_flags  <= w_l_flags;
        end
    end

`ifdef ITER_ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= OpAnd;
        end else if (w_accept) begin
            r_op <= w_op;
        end
    end
`endif

    assign result = r_result;
    assign flags  = r_flags;

    iter_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_long),
`ifdef ITER_ALU_DIV_EN
        .i_div     ((w_op == OpDiv) || (w_op == OpRem)),
`endif
        .i_step    (r_state == StBusy),
        .i_a       (a),
        .i_b       (b),
        .o_last    (w_md_last),
        .o_hi_next (w_md_hi),
        .o_lo_next (w_md_lo)
    );

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

    localparam int W = 8;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        time         t_acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op_s = 3'b0;
    logic [W-1:0] a_s = '0;
    logic [W-1:0] b_s = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  result;
    logic [3:0]   flags;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t cur;
    bit   held = 0;
    bit   hold_req = 0;
    int   hold_left = 0;

    iter_alu #(
        .WIDTH(W),
        .OPW  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op_s),
        .a        (a_s),
        .b        (b_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r = 0;
        int   sa, sb, sv;
        bit   dz = 0, ov = 0, cy = 0;
        int   lat = 1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: r = a & b;
            1: r = a | b;
            7: r = a ^ b;
            2: begin
                r = (a + b) % 256; cy = (a + b) > 255;
                sv = sa + sb; ov = (sv > 127) || (sv < -128);
            end
            3: begin
                r = (a - b + 256) % 256; cy = a < b;
                sv = sa - sb; ov = (sv > 127) || (sv < -128);
            end
            4: begin r = a * b; lat = W + 1; end
`ifdef ITER_ALU_DIV_EN
            5: if (b == 0) begin r = 255; dz = 1; end else begin r = a / b; lat = W + 1; end
            6: if (b == 0) begin r = a;   dz = 1; end else begin r = a % b; lat = W + 1; end
`else
            5: begin r = 0; dz = 1; end
            6: begin r = 0; dz = 1; end
`endif
            default: r = 0;
        endcase
        e.res   = r[15:0];
        e.flg   = {dz, ov, cy, (r == 0)};
        e.lat   = lat;
        e.t_acc = 0;
        return e;
    endfunction

    task automatic issue(input int op, input int a, input int b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        op_s = op[2:0];
        a_s  = a[W-1:0];
        b_s  = b[W-1:0];
        e = model(op, a, b);
        @(posedge clk);
        e.t_acc = $time;
        sbq.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    // Monitor / scoreboard: pops one expectation per presented result.
    always @(negedge clk) begin
        if (!rst_n) begin
            held      = 0;
            hold_req  = 0;
            hold_left = 0;
            out_ready = 1'b1;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_when_valid", in_ready, 0);
                if (!held) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_out_valid", 1, 0);
                    end else begin
                        cur = sbq.pop_front();
                        chk("result", result, cur.res);
                        chk("flags", flags, cur.flg);
                        chk("latency", ($time - cur.t_acc + 5) / 10, cur.lat);
                        if (hold_req) begin
                            hold_left = 5;
                            hold_req  = 0;
                        end
                    end
                    held = 1;
                end else begin
                    chk("hold_result", result, cur.res);
                    chk("hold_flags", flags, cur.flg);
                end
            end
            if (hold_req || hold_left > 0) begin
                out_ready = 1'b0;
                if (out_valid && hold_left > 0) hold_left--;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
            if (out_valid && out_ready) held = 0;
        end
    end

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Directed cases
        issue(2, 200, 100);
        issue(3, 3, 5);
        issue(3, 8'h7F, 8'hFF);
        issue(4, 255, 255);
        issue(5, 200, 7);
        issue(6, 200, 7);
        issue(5, 9, 0);
        issue(6, 9, 0);
        issue(4, 0, 77);
        issue(0, 8'hF0, 8'h3C);
        issue(1, 8'hF0, 8'h3C);
        issue(7, 8'hAA, 8'hAA);
        issue(2, 8'h80, 8'h80);
        drain();

        // Held result: out_ready low 5 cycles, in_valid must be ignored meanwhile
        hold_req = 1;
        issue(4, 13, 11);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_seen_valid", out_valid, 1);
        in_valid = 1'b1;
        op_s = 3'd2;
        a_s  = 8'd1;
        b_s  = 8'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of an iterative operation
`ifdef ITER_ALU_DIV_EN
        issue(5, 200, 7);
`else
        issue(4, 200, 7);
`endif
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sbq.delete();
        #1 chk("mid_rst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_in_ready", in_ready, 1);
        end
        issue(2, 1, 1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            int rop, ra, rb;
            rop = $urandom_range(7);
            ra  = $urandom_range(255);
            rb  = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
            issue(rop, ra, rb);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
